sram_arbiter: RTL and testbench

- N-master shared-SRAM arbiter. Generalises the single switch-to-SRAM point link so several switch pipelines (parser, lookup, action, config loader) share one synchronous SRAM.
- Arbitrates per cycle using fixed-priority or round-robin mode. Supports a grant lock for atomic multi-access sequences.
- Routes one-cycle-latency read data back to the issuing master with a per-master valid strobe.
- Sits between the switch masters and the existing sram instance in switch_sopc.

---
 rtl/sram_arbiter_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/sram_arbiter.sv | 55 +++++
 tb/tb_sram_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared arbitration mode constants and index helpers
package sram_arbiter_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  function automatic int wrap_add(int a, int b, int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: per-cycle fixed-priority or round-robin grant with lock support
module rr_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = ARB_RR,
  localparam int IW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_lock,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_lock_owner;
  logic          r_lock_valid;
  logic          w_lock_hit;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_idx;
  assign w_lock_hit = r_lock_valid && i_req[r_lock_owner];
  assign w_base     = (MODE == ARB_FIXED) ? '0 : r_ptr;
  assign o_valid    = !rst && (|i_req);
  assign o_idx      = w_idx;
  assign o_gnt      = o_valid ? (N'(1) << w_idx) : '0;
  // Scan downward from the lowest-priority slot so the highest-priority requester is written last
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[IW'(wrap_add(int'(w_base), i, N))]) w_idx = IW'(wrap_add(int'(w_base), i, N));
    if (w_lock_hit) w_idx = r_lock_owner;
  end
  // Advance the pointer past every winner; a lock drops as soon as its owner stops requesting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_lock_valid <= 1'b0;
      r_lock_owner <= '0;
    end else if (o_valid) begin
      r_ptr        <= IW'(wrap_add(int'(w_idx), 1, N));
      r_lock_valid <= i_lock[w_idx];
      r_lock_owner <= w_idx;
    end else if (r_lock_valid && !i_req[r_lock_owner]) begin
      r_lock_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one synchronous SRAM among N masters with one-cycle read return
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ARB_MODE  = ARB_RR,
  localparam int SEL_W    = DATA_W / 8,
  localparam int IW       = $clog2(N_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_ce_i,
  input  logic [N_MASTERS-1:0]          m_we_i,
  input  logic [N_MASTERS-1:0]          m_lock_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*SEL_W-1:0]    m_sel_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_data_i,
  output logic [N_MASTERS-1:0]          m_ack_o,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic [DATA_W-1:0]             m_data_o,
  output logic                          sram_ce_o,
  output logic                          sram_we_o,
  output logic [ADDR_W-1:0]             sram_addr_o,
  output logic [SEL_W-1:0]              sram_sel_o,
  output logic [DATA_W-1:0]             sram_data_o,
  input  logic [DATA_W-1:0]             sram_data_i
);
  logic [N_MASTERS-1:0] w_gnt;
  logic [IW-1:0]        w_idx;
  logic                 w_valid;
  logic [N_MASTERS-1:0] r_rvalid;
  rr_arbiter #(.N(N_MASTERS), .MODE(ARB_MODE)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  (m_ce_i),
    .i_lock (m_lock_i),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );
  assign m_ack_o     = w_gnt;
  assign sram_ce_o   = w_valid;
  assign sram_we_o   = w_valid && m_we_i[w_idx];
  assign sram_addr_o = w_valid ? m_addr_i[w_idx*ADDR_W +: ADDR_W] : '0;
  assign sram_sel_o  = w_valid ? m_sel_i[w_idx*SEL_W +: SEL_W] : '0;
  assign sram_data_o = w_valid ? m_data_i[w_idx*DATA_W +: DATA_W] : '0;
  assign m_data_o    = sram_data_i;
  assign m_rvalid_o  = rst ? '0 : r_rvalid;
  // Remember which master issued a read so its strobe lines up with the SRAM's one-cycle latency
  always_ff @(posedge clk) begin
    r_rvalid <= (rst || !w_valid || m_we_i[w_idx]) ? '0 : w_gnt;
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of arbitration, lock, read return and reset
module tb_sram_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   ce, we, lk;
  logic [127:0] addr;
  logic [15:0]  sel;
  logic [127:0] wdat;
  logic [3:0]   ack, rv, f_ack, f_rv;
  logic [31:0]  mdo, f_mdo, rdata;
  logic         s_ce, s_we, f_ce, f_we;
  logic [31:0]  s_addr, s_wd, f_addr, f_wd;
  logic [3:0]   s_sel, f_sel;
  logic [31:0]  mem [0:255];
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut (
    .clk(clk), .rst(rst), .m_ce_i(ce), .m_we_i(we), .m_lock_i(lk),
    .m_addr_i(addr), .m_sel_i(sel), .m_data_i(wdat),
    .m_ack_o(ack), .m_rvalid_o(rv), .m_data_o(mdo),
    .sram_ce_o(s_ce), .sram_we_o(s_we), .sram_addr_o(s_addr),
    .sram_sel_o(s_sel), .sram_data_o(s_wd), .sram_data_i(rdata)
  );

  sram_arbiter #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .m_ce_i(ce), .m_we_i(we), .m_lock_i(lk),
    .m_addr_i(addr), .m_sel_i(sel), .m_data_i(wdat),
    .m_ack_o(f_ack), .m_rvalid_o(f_rv), .m_data_o(f_mdo),
    .sram_ce_o(f_ce), .sram_we_o(f_we), .sram_addr_o(f_addr),
    .sram_sel_o(f_sel), .sram_data_o(f_wd), .sram_data_i(rdata)
  );

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (s_ce && s_we) begin
      for (int b = 0; b < 4; b++)
        if (s_sel[b]) mem[s_addr[7:0]][b*8 +: 8] <= s_wd[b*8 +: 8];
    end else if (s_ce) begin
      rdata <= mem[s_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] w, input logic [3:0] l);
    ce = c;
    we = w;
    lk = l;
  endtask

  task automatic master(input int k, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    addr[k*32 +: 32] = a;
    sel[k*4 +: 4]    = s;
    wdat[k*32 +: 32] = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'hF, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) master(k, 32'h100 + k, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ack", ack, 4'h0);
      check("rst_sram_ce", s_ce, 1'b0);
      check("rst_rvalid", rv, 4'h0);
      tick;
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_ack", ack, 4'b0001 << (i % 4));
      check("rr_addr", s_addr, 32'h100 + (i % 4));
      check("rr_rvalid", rv, (i == 0) ? 4'h0 : 4'b0001 << ((i - 1) % 4));
      if (i == 0) check("fx_ack_all", f_ack, 4'b0001);
      tick;
    end
    drive(4'b1010, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fx_ack_13", f_ack, 4'b0010);
      check("rr_ack_13", ack, (i == 1) ? 4'b1000 : 4'b0010);
      tick;
    end
    drive(4'b1000, 4'h0, 4'h0);
    @(negedge clk);
    check("fx_ack_3", f_ack, 4'b1000);
    check("rr_ack_3", ack, 4'b1000);
    tick;
    master(2, 32'h10, 4'hF, 32'hDEADBEEF);
    drive(4'b0100, 4'b0100, 4'h0);
    @(negedge clk);
    check("wr_ack", ack, 4'b0100);
    check("wr_we", s_we, 1'b1);
    check("wr_data", s_wd, 32'hDEADBEEF);
    check("wr_addr", s_addr, 32'h10);
    check("prev_rd_rvalid", rv, 4'b1000);
    tick;
    drive(4'b0100, 4'h0, 4'h0);
    @(negedge clk);
    check("rd_ack", ack, 4'b0100);
    check("wr_no_rvalid", rv, 4'h0);
    check("rd_we", s_we, 1'b0);
    tick;
    drive(4'h0, 4'h0, 4'h0);
    @(negedge clk);
    check("rd_rvalid", rv, 4'b0100);
    check("rd_data", mdo, 32'hDEADBEEF);
    check("idle_ce", s_ce, 1'b0);
    check("idle_addr", s_addr, 32'h0);
    tick;
    @(negedge clk);
    check("rvalid_one_cycle", rv, 4'h0);
    tick;
    drive(4'b0001, 4'h0, 4'h0);
    @(negedge clk);
    check("wrap_ack", ack, 4'b0001);
    tick;
    drive(4'hF, 4'h0, 4'h0);
    @(negedge clk);
    check("wrap_ptr1", ack, 4'b0010);
    tick;
    master(0, 32'h10, 4'b0010, 32'h00005500);
    drive(4'b0001, 4'b0001, 4'h0);
    @(negedge clk);
    check("bsel_wr_ack", ack, 4'b0001);
    check("bsel_sel", s_sel, 4'b0010);
    tick;
    drive(4'b0001, 4'h0, 4'h0);
    @(negedge clk);
    check("bsel_rd_ack", ack, 4'b0001);
    tick;
    drive(4'h0, 4'h0, 4'h0);
    @(negedge clk);
    check("bsel_rvalid", rv, 4'b0001);
    check("bsel_data", mdo, 32'hDEAD55EF);
    tick;
    drive(4'b0011, 4'h0, 4'b0010);
    @(negedge clk);
    check("lock_a", ack, 4'b0010);
    tick;
    @(negedge clk);
    check("lock_b", ack, 4'b0010);
    tick;
    drive(4'b0011, 4'h0, 4'b0000);
    @(negedge clk);
    check("lock_c", ack, 4'b0010);
    tick;
    drive(4'b0001, 4'h0, 4'h0);
    @(negedge clk);
    check("lock_d", ack, 4'b0001);
    tick;
    drive(4'b0011, 4'h0, 4'b0010);
    @(negedge clk);
    check("lock2_a", ack, 4'b0010);
    tick;
    drive(4'b0001, 4'h0, 4'h0);
    @(negedge clk);
    check("lock2_release", ack, 4'b0001);
    tick;
    drive(4'b0001, 4'h0, 4'h0);
    @(negedge clk);
    check("inflight_ack", ack, 4'b0001);
    tick;
    rst = 1'b1;
    drive(4'hF, 4'h0, 4'h0);
    @(negedge clk);
    check("inflight_rvalid", rv, 4'h0);
    check("inflight_ack_rst", ack, 4'h0);
    check("inflight_sram_ce", s_ce, 1'b0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", rv, 4'h0);
    check("post_rst_ptr0", ack, 4'b0001);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
